gpmc_wb_master: RTL and testbench
=================================

Name: gpmc_wb_master

Overview:
- Wishbone master that bridges the BeagleBone GPMC asynchronous bus into the FPGA clock domain.
- Synchronises the GPMC strobes and latches address and data.
- Issues single Wishbone classic read/write cycles toward the 1-master/N-slave shared-bus intercon.
- Sits directly upstream of the intercon; its wbm_* outputs drive the intercon master port one-to-one.

Parameters:
- ADDR_WIDTH, 8, Wishbone address width; taken from gpmc_ad_in[ADDR_WIDTH-1:0].
- DATA_WIDTH, 16, Wishbone and GPMC data width.
- SYNC_STAGES, 2, flop depth of the control-line and AD-bus synchronisers (minimum 2).
- ACK_TIMEOUT, 15, clk cycles of strobe without valid ack before abort (range 2..255).
- TIMEOUT_DATA, 16'hDEAD, read data returned on timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- gpmc_ad_in  in  DATA_WIDTH  GPMC multiplexed AD bus, input half.
- gpmc_ad_out  out  DATA_WIDTH  GPMC read data, output half.
- gpmc_ad_oe  out  1  top-level tristate enable for gpmc_ad_out.
- gpmc_csn  in  1  chip select, active low.
- gpmc_advn  in  1  address valid, active low.
- gpmc_oen  in  1  output enable (read), active low.
- gpmc_wen  in  1  write enable, active low.
- wbm_address  out  ADDR_WIDTH  Wishbone address.
- wbm_writedata  out  DATA_WIDTH  Wishbone write data.
- wbm_readdata  in  DATA_WIDTH  Wishbone read data.
- wbm_write  out  1  high = write cycle.
- wbm_cycle  out  1  bus cycle in progress.
- wbm_strobe  out  1  strobe.
- wbm_ack  in  1  acknowledge.
- err_timeout  out  1  one-cycle pulse on ack timeout.

Behaviour:
- Reset values:
  - Synchroniser flops for csn/advn/oen/wen reset to 1 (inactive).
  - All outputs reset to 0: gpmc_ad_out, gpmc_ad_oe, wbm_address, wbm_writedata, wbm_write, wbm_cycle, wbm_strobe, err_timeout.
  - FSM returns to IDLE on the clock edge where reset is sampled high, including mid-cycle. An open Wishbone cycle is dropped in that edge.
- Synchronisation:
  - csn/advn/oen/wen and gpmc_ad_in each pass through SYNC_STAGES flops, giving equal latency.
  - Edges are detected on the last synchroniser stage.
- FSM states and transitions:
  - IDLE -> ADDR: on advn rising edge while csn low. Latch address from synced ad.
  - ADDR -> RD: on oen falling. Assert cycle/strobe, write=0.
  - ADDR -> WR_DATA: on wen falling.
  - WR_DATA -> WR: on wen rising. Latch synced ad into wbm_writedata; assert cycle/strobe, write=1.
  - RD/WR: hold cycle/strobe until a valid ack, then deassert both on the next edge.
  - RD -> RD_HOLD: on valid ack. Capture wbm_readdata into gpmc_ad_out; assert gpmc_ad_oe.
  - RD_HOLD -> IDLE: on oen rising or csn rising. gpmc_ad_oe drops on the same edge.
  - WR -> IDLE: on valid ack.
- Ack qualification:
  - wbm_ack is ignored in the first cycle of strobe assertion (it may be stale from the previous transfer).
  - A valid ack is wbm_ack high in strobe cycle 2 or later. Minimum Wishbone transfer length is 2 cycles.
- Timeout:
  - An 8-bit counter counts strobe cycles.
  - At ACK_TIMEOUT: deassert cycle/strobe, pulse err_timeout for one cycle.
  - Read: present TIMEOUT_DATA and go to RD_HOLD. Write: go to IDLE.
- Abort cases:
  - csn rising in ADDR or WR_DATA: return to IDLE with no Wishbone cycle issued.
  - csn rising during RD/WR: the cycle completes (ack or timeout). Read data is discarded, gpmc_ad_oe stays 0, then IDLE.
  - A new advn edge while not in IDLE/ADDR is ignored.
- Output rules:
  - gpmc_ad_oe is never high unless synced oen is low and csn is low.
  - wbm_address and wbm_writedata hold their value between transfers.

Decomposition:
- Shared package gpmc_wb_pkg: FSM state enum (IDLE, ADDR, WR_DATA, WR, RD, RD_HOLD), TIMEOUT_DATA default, counter width constant.
- One sub-module, gpmc_sync: parameterised SYNC_STAGES flop chain with reset value and rising/falling edge outputs. Instantiated for the control lines and the AD bus.

Test Plan:
- GPMC write addr 8'h41, data 16'h1234 -> one cycle with wbm_write=1, address 8'h41, writedata 16'h1234. Strobe lasts 2+ cycles; ack in strobe cycle 1 is ignored.
- GPMC read addr 8'h02, slave returns 16'hA5A5 with ack in strobe cycle 2 -> gpmc_ad_out=16'hA5A5 with gpmc_ad_oe=1 until oen rises, then oe=0.
- Read with wbm_ack held 0 -> strobe drops after 15 cycles, err_timeout pulses once, gpmc_ad_out=16'hDEAD.
- csn deasserted after advn but before oen/wen -> no wbm_cycle assertion; FSM back in IDLE.
- Reset asserted during RD with strobe high -> wbm_cycle/wbm_strobe/gpmc_ad_oe=0 the next edge; a subsequent write completes normally.
- Back-to-back write then read with wbm_ack left high from the write -> read strobe still lasts 2+ cycles; correct read data is returned.

Source files
------------

// File: rtl/gpmc_wb_pkg.sv
`default_nettype none
// ============================================================================
// Package : gpmc_wb_pkg
// Brief   : Shared constants and FSM encoding for the GPMC-to-Wishbone master.
// Revision: 1.0 - initial release
// ============================================================================
package gpmc_wb_pkg;

    localparam int          c_CNT_WIDTH    = 8;
    localparam logic [15:0] c_TIMEOUT_DATA = 16'hDEAD;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE    = 3'd0;
    localparam state_t c_ST_ADDR    = 3'd1;
    localparam state_t c_ST_WR_DATA = 3'd2;
    localparam state_t c_ST_WR      = 3'd3;
    localparam state_t c_ST_RD      = 3'd4;
    localparam state_t c_ST_RD_HOLD = 3'd5;

endpackage
`default_nettype wire

// File: rtl/gpmc_wb_master_if.sv
`default_nettype none
// ============================================================================
// Interface : gpmc_wb_master_if
// Brief     : Wishbone classic single-master bus between bridge and intercon.
// Revision  : 1.0 - initial release
// ============================================================================
interface gpmc_wb_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] wbm_address;
    logic [DATA_WIDTH-1:0] wbm_writedata;
    logic [DATA_WIDTH-1:0] wbm_readdata;
    logic                  wbm_write;
    logic                  wbm_cycle;
    logic                  wbm_strobe;
    logic                  wbm_ack;

    modport master (
        output wbm_address, wbm_writedata, wbm_write, wbm_cycle, wbm_strobe,
        input  wbm_readdata, wbm_ack
    );

    modport slave (
        input  wbm_address, wbm_writedata, wbm_write, wbm_cycle, wbm_strobe,
        output wbm_readdata, wbm_ack
    );
endinterface
`default_nettype wire

// File: rtl/gpmc_sync.sv
`default_nettype none
// ============================================================================
// Module  : gpmc_sync
// Brief   : STAGES-deep synchroniser with edge detect on the last stage.
// Revision: 1.0 - initial release
// ============================================================================
module gpmc_sync #(
    parameter int   WIDTH     = 1,
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);
    logic [WIDTH-1:0] r_chain [STAGES];
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                r_chain[i] <= {WIDTH{RESET_VAL}};
            end
            r_prev <= {WIDTH{RESET_VAL}};
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
            r_prev <= r_chain[STAGES-1];
        end
    end

    assign o_q    = r_chain[STAGES-1];
    assign o_rise = o_q & ~r_prev;
    assign o_fall = ~o_q & r_prev;
endmodule
`default_nettype wire

// File: rtl/gpmc_wb_master.sv
`default_nettype none
// ============================================================================
// Module  : gpmc_wb_master
// Brief   : Bridges the asynchronous GPMC bus into single Wishbone cycles.
// Revision: 1.0 - initial release
// ============================================================================
module gpmc_wb_master
    import gpmc_wb_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 8,
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    SYNC_STAGES  = 2,
    parameter int                    ACK_TIMEOUT  = 15,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = c_TIMEOUT_DATA
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] gpmc_ad_in,
    output logic [DATA_WIDTH-1:0] gpmc_ad_out,
    output logic                  gpmc_ad_oe,
    input  logic                  gpmc_csn,
    input  logic                  gpmc_advn,
    input  logic                  gpmc_oen,
    input  logic                  gpmc_wen,
    gpmc_wb_master_if.master      wb,
    output logic                  err_timeout
);
    localparam logic [c_CNT_WIDTH-1:0] c_ACK_LIMIT = c_CNT_WIDTH'(ACK_TIMEOUT);
    localparam logic [c_CNT_WIDTH-1:0] c_ACK_FIRST = c_CNT_WIDTH'(2);

    logic [3:0]            w_ctl, w_ctl_rise, w_ctl_fall;
    logic [DATA_WIDTH-1:0] w_ad, w_ad_rise_unused, w_ad_fall_unused;
    logic                  w_csn, w_oen, w_csn_rise, w_advn_rise;
    logic                  w_oen_fall, w_wen_fall, w_wen_rise;
    logic                  w_ack_valid, w_timeout, w_unused;

    state_t                r_state;
    logic [c_CNT_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [DATA_WIDTH-1:0] r_writedata, r_ad_out;
    logic                  r_write, r_cycle, r_strobe, r_oe, r_abort, r_err_timeout;

    gpmc_sync #(.WIDTH(4), .STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ctl_sync (
        .clk(clk), .reset(reset),
        .i_d({gpmc_csn, gpmc_advn, gpmc_oen, gpmc_wen}),
        .o_q(w_ctl), .o_rise(w_ctl_rise), .o_fall(w_ctl_fall)
    );

    gpmc_sync #(.WIDTH(DATA_WIDTH), .STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_ad_sync (
        .clk(clk), .reset(reset), .i_d(gpmc_ad_in),
        .o_q(w_ad), .o_rise(w_ad_rise_unused), .o_fall(w_ad_fall_unused)
    );

    assign w_csn       = w_ctl[3];
    assign w_oen       = w_ctl[1];
    assign w_csn_rise  = w_ctl_rise[3];
    assign w_advn_rise = w_ctl_rise[2];
    assign w_oen_fall  = w_ctl_fall[1];
    assign w_wen_rise  = w_ctl_rise[0];
    assign w_wen_fall  = w_ctl_fall[0];
    assign w_unused    = &{1'b0, w_ctl[2], w_ctl[0], w_ctl_fall[3:2], w_ctl_rise[1]};

    // Strobe cycle 1 may still see the previous transfer's ack, so it is ignored.
    assign w_ack_valid = wb.wbm_ack && (r_cnt >= c_ACK_FIRST);
    assign w_timeout   = (r_cnt == c_ACK_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_cnt         <= '0;
            r_address     <= '0;
            r_writedata   <= '0;
            r_ad_out      <= '0;
            r_write       <= 1'b0;
            r_cycle       <= 1'b0;
            r_strobe      <= 1'b0;
            r_oe          <= 1'b0;
            r_abort       <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_err_timeout <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_advn_rise && !w_csn) begin
                        r_address <= w_ad[ADDR_WIDTH-1:0];
                        r_state   <= c_ST_ADDR;
                    end
                end
                c_ST_ADDR: begin
                    if (w_csn_rise) begin
                        r_state <= c_ST_IDLE;
                    end else if (w_advn_rise && !w_csn) begin
                        r_address <= w_ad[ADDR_WIDTH-1:0];
                    end else if (w_oen_fall) begin
                        r_state  <= c_ST_RD;
                        r_cycle  <= 1'b1;
                        r_strobe <= 1'b1;
                        r_write  <= 1'b0;
                        r_cnt    <= c_CNT_WIDTH'(1);
                        r_abort  <= 1'b0;
                    end else if (w_wen_fall) begin
                        r_state <= c_ST_WR_DATA;
                    end
                end
                c_ST_WR_DATA: begin
                    if (w_csn_rise) begin
                        r_state <= c_ST_IDLE;
                    end else if (w_wen_rise) begin
                        r_writedata <= w_ad;
                        r_state     <= c_ST_WR;
                        r_cycle     <= 1'b1;
                        r_strobe    <= 1'b1;
                        r_write     <= 1'b1;
                        r_cnt       <= c_CNT_WIDTH'(1);
                        r_abort     <= 1'b0;
                    end
                end
                c_ST_RD, c_ST_WR: begin
                    if (w_csn_rise) begin
                        r_abort <= 1'b1;
                    end
                    if (w_ack_valid || w_timeout) begin
                        r_cycle       <= 1'b0;
                        r_strobe      <= 1'b0;
                        r_write       <= 1'b0;
                        r_cnt         <= '0;
                        r_err_timeout <= !w_ack_valid;
                        // A deselected read still finishes on the bus, but its data is dropped.
                        if ((r_state == c_ST_RD) && !r_abort && !w_csn) begin
                            r_ad_out <= w_ack_valid ? wb.wbm_readdata : TIMEOUT_DATA;
                            r_oe     <= 1'b1;
                            r_state  <= c_ST_RD_HOLD;
                        end else begin
                            r_state <= c_ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_WIDTH'(1);
                    end
                end
                c_ST_RD_HOLD: begin
                    // Level test also catches an oen/csn edge that passed during RD.
                    if (w_oen || w_csn) begin
                        r_oe    <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign gpmc_ad_out      = r_ad_out;
    assign gpmc_ad_oe       = r_oe && !w_oen && !w_csn;
    assign err_timeout      = r_err_timeout;
    assign wb.wbm_address   = r_address;
    assign wb.wbm_writedata = r_writedata;
    assign wb.wbm_write     = r_write;
    assign wb.wbm_cycle     = r_cycle;
    assign wb.wbm_strobe    = r_strobe;
endmodule
`default_nettype wire

// File: tb/tb_gpmc_wb_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_gpmc_wb_master
// Brief   : Directed self-checking bench for the GPMC-to-Wishbone master.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gpmc_wb_master;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ad_in;
    logic [15:0] ad_out;
    logic        ad_oe;
    logic        csn, advn, oen, wen;
    logic        err_timeout;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          len;
    logic [7:0]  cap_addr;
    logic [15:0] cap_wd;
    logic        cap_we;
    logic        seen;

    gpmc_wb_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) wb ();

    gpmc_wb_master #(
        .ADDR_WIDTH(8), .DATA_WIDTH(16), .SYNC_STAGES(2),
        .ACK_TIMEOUT(15), .TIMEOUT_DATA(16'hDEAD)
    ) dut (
        .clk(clk), .reset(reset),
        .gpmc_ad_in(ad_in), .gpmc_ad_out(ad_out), .gpmc_ad_oe(ad_oe),
        .gpmc_csn(csn), .gpmc_advn(advn), .gpmc_oen(oen), .gpmc_wen(wen),
        .wb(wb), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Waits for strobe, then acks from strobe cycle ack_from on (0 = never); n = strobe length.
    task automatic strobe_run(input int ack_from, input bit keep_ack, output int n);
        int guard;
        guard = 0;
        n = 0;
        while (wb.wbm_strobe !== 1'b1 && guard < 40) begin
            ticks(1);
            guard++;
        end
        cap_addr = wb.wbm_address;
        cap_wd   = wb.wbm_writedata;
        cap_we   = wb.wbm_write;
        while (wb.wbm_strobe === 1'b1 && n < 40) begin
            n++;
            wb.wbm_ack = (ack_from != 0) && (n >= ack_from);
            ticks(1);
        end
        if (!keep_ack) wb.wbm_ack = 1'b0;
    endtask

    task automatic gpmc_addr_phase(input logic [15:0] a);
        csn = 1'b0; ad_in = a; advn = 1'b0;
        ticks(3);
        advn = 1'b1;
        ticks(4);
    endtask

    task automatic gpmc_write(input logic [7:0] a, input logic [15:0] d,
                              input int ack_from, input bit keep_ack);
        gpmc_addr_phase({8'h00, a});
        ad_in = d; wen = 1'b0;
        ticks(4);
        wen = 1'b1;
        strobe_run(ack_from, keep_ack, len);
        csn = 1'b1;
        ticks(4);
    endtask

    initial begin
        reset = 1'b1; csn = 1'b1; advn = 1'b1; oen = 1'b1; wen = 1'b1; ad_in = '0;
        wb.wbm_ack = 1'b0; wb.wbm_readdata = '0;
        ticks(3);
        check_value("rst_ctrl", {ad_oe, wb.wbm_cycle, wb.wbm_strobe, wb.wbm_write, err_timeout}, 0);
        check_value("rst_data", {ad_out, wb.wbm_address, wb.wbm_writedata}, 0);
        reset = 1'b0;
        ticks(2);

        // Write with an ack already present in strobe cycle 1
        gpmc_write(8'h41, 16'h1234, 1, 1'b0);
        check_value("wr_len", len, 2);
        check_value("wr_fields", {cap_we, cap_addr, cap_wd}, {1'b1, 8'h41, 16'h1234});
        check_value("wr_hold", {wb.wbm_address, wb.wbm_writedata}, {8'h41, 16'h1234});

        // Read, ack in strobe cycle 2
        wb.wbm_readdata = 16'hA5A5;
        gpmc_addr_phase(16'h0002);
        oen = 1'b0;
        strobe_run(2, 1'b0, len);
        check_value("rd_len", len, 2);
        check_value("rd_fields", {cap_we, cap_addr}, {1'b0, 8'h02});
        check_value("rd_data", ad_out, 16'hA5A5);
        check_value("rd_oe", ad_oe, 1'b1);
        ticks(3);
        check_value("rd_oe_hold", ad_oe, 1'b1);
        oen = 1'b1;
        ticks(5);
        check_value("rd_oe_off", ad_oe, 1'b0);
        csn = 1'b1;
        ticks(4);

        // Read timeout
        wb.wbm_readdata = 16'h5555;
        gpmc_addr_phase(16'h0003);
        oen = 1'b0;
        strobe_run(0, 1'b0, len);
        check_value("to_len", len, 15);
        check_value("to_err", err_timeout, 1'b1);
        check_value("to_data", ad_out, 16'hDEAD);
        check_value("to_oe", ad_oe, 1'b1);
        ticks(1);
        check_value("to_err_once", err_timeout, 1'b0);
        oen = 1'b1;
        ticks(5);
        csn = 1'b1;
        ticks(4);

        // Deselect after the address phase: no bus cycle, even on a later oen fall
        seen = 1'b0;
        gpmc_addr_phase(16'h0077);
        csn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 6) oen = 1'b0;
            if (wb.wbm_cycle === 1'b1) seen = 1'b1;
            ticks(1);
        end
        oen = 1'b1;
        ticks(4);
        check_value("ab_no_cycle", seen, 1'b0);

        // Reset in the middle of a read
        gpmc_addr_phase(16'h0005);
        oen = 1'b0;
        for (int i = 0; i < 40 && wb.wbm_strobe !== 1'b1; i++) ticks(1);
        ticks(3);
        check_value("rr_stb_before", wb.wbm_strobe, 1'b1);
        reset = 1'b1;
        ticks(1);
        check_value("rr_after", {wb.wbm_cycle, wb.wbm_strobe, ad_oe}, 0);
        csn = 1'b1; oen = 1'b1;
        ticks(2);
        reset = 1'b0;
        ticks(4);
        gpmc_write(8'h10, 16'hBEEF, 2, 1'b0);
        check_value("rr_wr_len", len, 2);
        check_value("rr_wr_fields", {cap_we, cap_addr, cap_wd}, {1'b1, 8'h10, 16'hBEEF});

        // Back-to-back write then read with ack left high
        gpmc_write(8'h20, 16'h0F0F, 3, 1'b1);
        check_value("b2b_wr_len", len, 3);
        wb.wbm_readdata = 16'h3C3C;
        gpmc_addr_phase(16'h0021);
        oen = 1'b0;
        strobe_run(1, 1'b0, len);
        check_value("b2b_rd_len", len, 2);
        check_value("b2b_rd_addr", cap_addr, 8'h21);
        check_value("b2b_rd_data", {ad_oe, ad_out}, {1'b1, 16'h3C3C});
        oen = 1'b1;
        ticks(5);
        csn = 1'b1;
        ticks(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
`default_nettype wire
